da_fir_engine: RTL and testbench

- Bit-serial distributed-arithmetic FIR engine that sits between the sample stream and the DA coefficient ROM.
- Holds the tap delay line and presents one ROM address per input bit, MSB first.
- Consumes the ROM's registered word one cycle later and shift-accumulates it into a full-precision filter output.
- Drives a valid/ready output stream.

---
 rtl/da_fir_engine.sv | 107 ++++++++++
 tb/tb_da_fir_engine.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/da_fir_engine.sv
// Bit-serial distributed-arithmetic FIR engine: MSB-first ROM addressing, shift-accumulate output.
// Define DA_FOLDED_ROM_EN when the coefficient ROM stores the folded half table.
module da_fir_engine #(
  parameter int word_width   = 16,
  parameter int data_width   = 16,
  parameter int filter_order = 4,
  parameter logic signed [word_width-1:0] OFFSET = '0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [data_width-1:0]          in_data,
  output logic [filter_order-1:0]               rom_addr,
  input  logic signed [word_width-1:0]          rom_q,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [word_width+data_width:0] out_data
);
  localparam int acc_width = word_width + data_width + 1;
  localparam int cnt_width = $clog2(data_width);
  localparam logic [cnt_width-1:0] bit_top = cnt_width'(data_width - 1);

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;
  state_t state, state_nxt;

  logic signed [data_width-1:0] tap [filter_order];
  logic [cnt_width-1:0]         n;
  logic                         accept;
  logic                         d_valid, d_first, d_last;
  logic signed [acc_width-1:0]  acc, rom_ext, term, sum, offset_ext;

  assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign rom_ext    = {{(acc_width-word_width){rom_q[word_width-1]}}, rom_q};
  assign offset_ext = {{(acc_width-word_width){OFFSET[word_width-1]}}, OFFSET};
  assign sum        = {acc[acc_width-2:0], 1'b0} + term;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (n == '0) state_nxt = LAST;
      LAST:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One bit-slice of every tap forms the address; tap[0] lands in the LSB.
  always_comb begin
    rom_addr = '0;
    if (state == RUN)
      for (int unsigned k = 0; k < filter_order; k++) rom_addr[k] = tap[k][n];
  end

`ifdef DA_FOLDED_ROM_EN
  logic d_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_msb <= 1'b0;
    else        d_msb <= rom_addr[filter_order-1];
  end

  always_comb begin
    term = rom_ext;
    if (d_msb) term = -rom_ext;
  end
`else
  always_comb begin
    term = rom_ext;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n         <= '0;
      d_valid   <= 1'b0;
      d_first   <= 1'b0;
      d_last    <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int unsigned k = 0; k < filter_order; k++) tap[k] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        n      <= bit_top;
        tap[0] <= in_data;
        for (int unsigned k = 1; k < filter_order; k++) tap[k] <= tap[k-1];
      end else if (state == RUN && n != '0) begin
        n <= n - cnt_width'(1);
      end
      // Flags ride one cycle behind the address so they line up with rom_q.
      d_valid <= (state == RUN);
      d_first <= (state == RUN) && (n == bit_top);
      d_last  <= (state == RUN) && (n == '0);
      if (d_valid) acc <= d_first ? -term : sum;
      if (d_valid && d_last) begin
        out_data  <= sum + offset_ext;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_da_fir_engine.sv
// Scoreboard bench for da_fir_engine (N=4, B=4) with a registered behavioural ROM.
// The reference model follows DA_FOLDED_ROM_EN the same way the engine does.
module tb_da_fir_engine;
  localparam int WW = 16;
  localparam int DW = 4;
  localparam int NT = 4;
  localparam int AW = WW + DW + 1;
  localparam logic signed [WW-1:0] OFFS = '0;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic [NT-1:0]        rom_addr;
  logic signed [WW-1:0] rom_q = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [AW-1:0] out_data;

  da_fir_engine #(
    .word_width(WW),
    .data_width(DW),
    .filter_order(NT),
    .OFFSET(OFFS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .rom_addr(rom_addr),
    .rom_q(rom_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  int                   checks = 0;
  int                   errors = 0;
  int                   rom_mode = 0;
  int                   rst_count = 0;
  bit                   rnd_rdy = 1'b0;
  logic signed [WW-1:0] rom_tab [16];
  int                   mtap [NT];
  longint               exp_q [$];

  // Mode 0: R(a)=a, mode 1: constant 3, otherwise a random table.
  function automatic logic signed [WW-1:0] rom_word(input logic [NT-1:0] a);
    if (rom_mode == 0) return WW'(a);
    if (rom_mode == 1) return WW'(3);
    return rom_tab[a];
  endfunction

  always @(posedge clk) rom_q <= rom_word(rom_addr);

  function automatic logic [NT-1:0] model_addr(input int n);
    logic [NT-1:0] a;
    for (int k = 0; k < NT; k++) a[k] = mtap[k][n];
    return a;
  endfunction

  // Two's-complement weighting of the bit-slices: the MSB slice weighs -2^(B-1).
  function automatic longint model_out();
    longint r;
    r = longint'(OFFS);
    for (int n = 0; n < DW; n++) begin
      logic [NT-1:0] a;
      longint w;
      longint s;
      a = model_addr(n);
      w = longint'(1) << n;
      s = 1;
      if (n == DW - 1) w = -w;
`ifdef DA_FOLDED_ROM_EN
      if (a[NT-1]) s = -1;
`endif
      r += w * s * longint'(rom_word(a));
    end
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin : acc_mon
    int rc;
    forever begin
      @(negedge clk);
      if (rst_n && in_valid && in_ready) begin
        for (int k = NT - 1; k > 0; k--) mtap[k] = mtap[k-1];
        mtap[0] = int'(in_data);
        exp_q.push_back(model_out());
        rc = rst_count;
        @(posedge clk);
        for (int i = 0; i < DW; i++) begin
          @(negedge clk);
          if (rst_count != rc) break;
          check("rom_addr", longint'(rom_addr), longint'(model_addr(DW - 1 - i)));
        end
      end
    end
  end

  initial begin : out_mon
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result got %0d expected no result", out_data);
        end else begin
          check("out_data", longint'(out_data), exp_q.pop_front());
        end
      end
    end
  end

  initial begin : rdy_drv
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got no finish expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_accept();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout got in_ready=0 expected accept within 64 cycles");
    in_valid = 1'b0;
  endtask

  task automatic send(input logic signed [DW-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    wait_accept();
  endtask

  task automatic get_result(output longint data, output int lat);
    data = 0;
    lat  = -1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (out_valid) begin
        data = longint'(out_data);
        lat  = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout got no out_valid expected one within 64 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rst_count++;
    exp_q.delete();
    foreach (mtap[k]) mtap[k] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : main
    longint d;
    longint e;
    int     lat;
    bit     seen;

    // Reset with a sample offered the whole time.
    #3;
    rst_n    = 1'b0;
    rst_count++;
    in_valid = 1'b1;
    in_data  = DW'(5);
    repeat (3) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_rom_addr", longint'(rom_addr), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    repeat (3) @(negedge clk);
    check("rst_no_accept", longint'(in_ready), 1);
    @(posedge clk);
    #1;

    // Identity ROM: result is the weighted sum of taps.
    rom_mode = 0;
    send(DW'(5));
    get_result(d, lat);
    check("latency", longint'(lat), DW + 2);
    check("dir_5", d, 5);
    send(DW'(-3));
    get_result(d, lat);
    check("dir_m3", d, 7);

    // Constant ROM of 3.
    rom_mode = 1;
    reset_pulse();
    send(DW'(0));
    get_result(d, lat);
    check("dir_const_0", d, -3);
    repeat (4) begin
      send(DW'(-1));
      get_result(d, lat);
    end
`ifdef DA_FOLDED_ROM_EN
    check("dir_all_ones", d, 3);
`else
    check("dir_all_ones", d, -3);
`endif

    // Backpressure: result must hold while a new sample waits.
    rom_mode  = 0;
    out_ready = 1'b0;
    send(DW'(6));
    get_result(d, lat);
    e = (exp_q.size() > 0) ? exp_q[0] : 64'sd999999;
    in_valid = 1'b1;
    in_data  = DW'(-5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_out_valid", longint'(out_valid), 1);
      check("bp_out_data", longint'(out_data), e);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    get_result(d, lat);

    // Reset while bit n=1 is being addressed.
    send(DW'(7));
    @(posedge clk);
    reset_pulse();
    seen = 1'b0;
    for (int i = 0; i < DW + 4; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("rst_mid_no_valid", longint'(seen), 0);
    @(posedge clk);
    #1;
    send(DW'(5));
    get_result(d, lat);
    check("rst_mid_5", d, 5);

    // Random samples through a random ROM table with random backpressure.
    for (int i = 0; i < 16; i++) rom_tab[i] = WW'($urandom);
    rom_mode = 2;
    rnd_rdy  = 1'b1;
    repeat (80) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      wait_accept();
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    check("drain_empty", longint'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
